packet_port_buffer: RTL and testbench

Per-output-port packet buffer downstream of the packet receiver. Captures one routed packet byte-by-byte from the receiver's write interface into a ping-pong pair of packet banks. Commits each packet on the receiver's `winc` pulse and replays committed packets to the output consumer over a valid/read-enable handshake. Drives the port's `wfull` back to the receiver for flow control. Three instances sit in the router, one per output port.

---
 rtl/router_pkg.sv | 20 ++
 rtl/packet_port_buffer_if.sv | 33 +++
 rtl/pkt_bank.sv | 62 ++++++
 rtl/packet_port_buffer.sv | 166 ++++++++++++++++
 tb/tb_packet_port_buffer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module : router_pkg
// Shared types and defaults for the router output-port packet buffers.
// Rev    : 1.0
// ============================================================================
package router_pkg;

    localparam int c_TIMEOUT_CYC = 30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } rd_state_t;

    typedef logic bank_idx_t;

endpackage
`default_nettype wire

// File: rtl/packet_port_buffer_if.sv
`default_nettype none
// ============================================================================
// Module : packet_port_buffer_if
// Receiver write side and consumer read side of one output-port buffer.
// Rev    : 1.0
// ============================================================================
interface packet_port_buffer_if #(
    parameter int PTR_IN_SZ = 4,
    parameter int UWIDTH    = 8
);
    logic                 wen;
    logic [PTR_IN_SZ-1:0] waddr;
    logic [UWIDTH-1:0]    wdata;
    logic                 winc;
    logic                 wfull;
    logic                 read_enb;
    logic                 vld_out;
    logic [UWIDTH-1:0]    data_out;
    logic                 last_out;
    logic                 drop_err;
    logic                 timeout_err;

    modport slave (
        input  wen, waddr, wdata, winc, read_enb,
        output wfull, vld_out, data_out, last_out, drop_err, timeout_err
    );

    modport master (
        output wen, waddr, wdata, winc, read_enb,
        input  wfull, vld_out, data_out, last_out, drop_err, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/pkt_bank.sv
`default_nettype none
// ============================================================================
// Module : pkt_bank
// One packet bank: byte storage, committed flag and length tracker.
// Rev    : 1.0
// ============================================================================
module pkt_bank
    import router_pkg::*;
#(
    parameter int PTR_IN_SZ = 4,
    parameter int UWIDTH    = 8
) (
    input  wire logic                 clk1,
    input  wire logic                 rst,
    input  wire logic                 i_wen,
    input  wire logic [PTR_IN_SZ-1:0] i_waddr,
    input  wire logic [UWIDTH-1:0]    i_wdata,
    input  wire logic                 i_commit,
    input  wire logic                 i_free,
    input  wire logic [PTR_IN_SZ-1:0] i_raddr,
    output logic      [UWIDTH-1:0]    o_rdata,
    output logic                      o_full,
    output logic                      o_full_nxt,
    output logic      [PTR_IN_SZ:0]   o_len,
    output logic      [PTR_IN_SZ:0]   o_len_nxt
);
    localparam int DEPTH = 2 ** PTR_IN_SZ;
    localparam int LW    = PTR_IN_SZ + 1;

    logic [UWIDTH-1:0] r_mem [DEPTH];
    logic              r_full;
    logic [LW-1:0]     r_len;
    logic [LW-1:0]     w_len_base;
    logic [LW-1:0]     w_waddr_p1;

    // Freeing restarts the length so a same-cycle write begins a new packet.
    assign w_len_base = i_free ? '0 : r_len;
    assign w_waddr_p1 = {1'b0, i_waddr} + LW'(1);
    assign o_len_nxt  = (i_wen && (w_waddr_p1 > w_len_base)) ? w_waddr_p1 : w_len_base;
    assign o_full_nxt = (r_full & ~i_free) | i_commit;

    assign o_rdata = r_mem[i_raddr];
    assign o_full  = r_full;
    assign o_len   = r_len;

    always_ff @(posedge clk1) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_len  <= '0;
        end else begin
            r_full <= o_full_nxt;
            r_len  <= o_len_nxt;
        end
    end

    always_ff @(posedge clk1) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end
endmodule
`default_nettype wire

// File: rtl/packet_port_buffer.sv
`default_nettype none
// ============================================================================
// Module : packet_port_buffer
// Ping-pong packet buffer for one router output port; PKT_BUF_TIMEOUT_EN adds a stall timeout.
// Rev    : 1.0
// ============================================================================
module packet_port_buffer
    import router_pkg::*;
#(
    parameter int PTR_IN_SZ   = 4,
    parameter int UWIDTH      = 8,
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
    input  wire logic           clk1,
    input  wire logic           rst,
    packet_port_buffer_if.slave bus
);
    localparam int LW = PTR_IN_SZ + 1;

    rd_state_t            r_state;
    rd_state_t            w_state_nxt;
    bank_idx_t            r_wb;
    bank_idx_t            r_rb;
    logic [PTR_IN_SZ-1:0] r_idx;
    logic                 r_wfull;
    logic                 r_drop_err;

    logic                 w_wb_full;
    logic                 w_wr_ok;
    logic                 w_commit;
    logic                 w_drop;
    logic                 w_free;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_vld;
    logic                 w_stall_hit;
    logic [UWIDTH-1:0]    w_data;
    logic [1:0]           w_full;
    logic [1:0]           w_full_nxt;
    logic [LW-1:0]        w_len     [2];
    logic [LW-1:0]        w_len_nxt [2];
    logic [UWIDTH-1:0]    w_rdata   [2];

    // A bank released by the reader this cycle may be refilled in the same cycle.
    assign w_wb_full = w_full[r_wb] & ~(w_free & (r_rb == r_wb));
    assign w_wr_ok   = bus.wen & ~w_wb_full;
    assign w_commit  = bus.winc & ~w_wb_full & (w_len_nxt[r_wb] != '0);
    // Only the overflowing packet is lost; the committed packet stays intact.
    assign w_drop    = bus.winc & w_wb_full;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        pkt_bank #(
            .PTR_IN_SZ (PTR_IN_SZ),
            .UWIDTH    (UWIDTH)
        ) u_bank (
            .clk1       (clk1),
            .rst        (rst),
            .i_wen      (w_wr_ok & (r_wb == bank_idx_t'(gi))),
            .i_waddr    (bus.waddr),
            .i_wdata    (bus.wdata),
            .i_commit   (w_commit & (r_wb == bank_idx_t'(gi))),
            .i_free     (w_free & (r_rb == bank_idx_t'(gi))),
            .i_raddr    (r_idx),
            .o_rdata    (w_rdata[gi]),
            .o_full     (w_full[gi]),
            .o_full_nxt (w_full_nxt[gi]),
            .o_len      (w_len[gi]),
            .o_len_nxt  (w_len_nxt[gi])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vld       = 1'b0;
        w_data      = '0;
        w_last      = 1'b0;
        w_accept    = 1'b0;
        w_free      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_full[r_rb]) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                w_vld  = 1'b1;
                w_data = w_rdata[r_rb];
                w_last = ({1'b0, r_idx} == (w_len[r_rb] - LW'(1)));
                if (bus.read_enb) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_free      = 1'b1;
                        w_state_nxt = ST_GAP;
                    end
                end else if (w_stall_hit) begin
                    w_free      = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
            r_idx      <= '0;
            r_wfull    <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wfull    <= w_full_nxt[0] & w_full_nxt[1];
            r_drop_err <= w_drop;
            if (w_commit) begin
                r_wb <= ~r_wb;
            end
            if (w_free) begin
                r_rb <= ~r_rb;
            end
            if (r_state == ST_IDLE) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef PKT_BUF_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);

    logic [SW-1:0] r_stall;
    logic          r_timeout_err;

    assign w_stall_hit = (r_state == ST_SEND) & ~bus.read_enb & (r_stall == SW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk1) begin
        if (!rst) begin
            r_stall       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_stall_hit;
            if ((r_state == ST_SEND) && !bus.read_enb && !w_stall_hit) begin
                r_stall <= r_stall + SW'(1);
            end else begin
                r_stall <= '0;
            end
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    // Constant-false stall: TIMEOUT_CYC only matters when the counter is built.
    assign w_stall_hit     = (TIMEOUT_CYC < 0);
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.vld_out  = w_vld;
    assign bus.data_out = w_data;
    assign bus.last_out = w_last;
    assign bus.wfull    = r_wfull;
    assign bus.drop_err = r_drop_err;
endmodule
`default_nettype wire

// File: tb/tb_packet_port_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_packet_port_buffer
// Directed stimulus with a packet-queue reference model checked every cycle.
// Rev    : 1.0
// ============================================================================
module tb_packet_port_buffer;
    localparam int PTR = 4;
    localparam int UW  = 8;
    localparam int TMO = 30;

    logic clk1 = 1'b0;
    logic rst;

    packet_port_buffer_if #(.PTR_IN_SZ(PTR), .UWIDTH(UW)) bus ();

    packet_port_buffer #(
        .PTR_IN_SZ   (PTR),
        .UWIDTH      (UW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: committed packets in arrival order plus the packet being written.
    logic [127:0] q_data [$];
    int           q_len  [$];
    logic [7:0]   wbuf   [16];
    int           wlen = 0;
    bit           m_send = 1'b0;
    int           m_idx = 0, m_stall = 0, m_earliest = 0;
    bit           m_drop = 1'b0, m_tmo = 1'b0;
    bit           armed = 1'b0;
    int           cyc = 0;

    bit           s_rst, s_wen, s_winc, s_ren;
    logic [3:0]   s_addr;
    logic [7:0]   s_d;
    logic [127:0] s_pk;

    logic [7:0]   got   [$];
    logic [7:0]   exp_q [$];
    bit           p_vld = 1'b0;
    logic [7:0]   p_data;
    int           n_drop_seen = 0, n_tmo_seen = 0, rise_cyc = 0, winc_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk1) begin
        s_rst  = rst;
        s_wen  = bus.wen;
        s_winc = bus.winc;
        s_ren  = bus.read_enb;
        s_addr = bus.waddr;
        s_d    = bus.wdata;
        cyc++;
        if (s_rst && p_vld && s_ren) got.push_back(p_data);
        if (s_winc) winc_cyc = cyc;
        m_drop = 1'b0;
        m_tmo  = 1'b0;
        if (!s_rst) begin
            q_data.delete();
            q_len.delete();
            wlen       = 0;
            m_send     = 1'b0;
            m_stall    = 0;
            m_earliest = cyc + 1;
            armed      = 1'b1;
        end else begin
            if (m_send) begin
                if (s_ren) begin
                    m_stall = 0;
                    if (m_idx == q_len[0] - 1) begin
                        void'(q_data.pop_front());
                        void'(q_len.pop_front());
                        m_send     = 1'b0;
                        m_earliest = cyc + 2;
                    end else begin
                        m_idx++;
                    end
                end else begin
`ifdef PKT_BUF_TIMEOUT_EN
                    m_stall++;
                    if (m_stall == TMO) begin
                        void'(q_data.pop_front());
                        void'(q_len.pop_front());
                        m_send     = 1'b0;
                        m_earliest = cyc + 2;
                        m_tmo      = 1'b1;
                        m_stall    = 0;
                    end
`endif
                end
            end else if (cyc >= m_earliest && q_len.size() > 0) begin
                m_send  = 1'b1;
                m_idx   = 0;
                m_stall = 0;
            end
            if (q_len.size() < 2) begin
                if (s_wen) begin
                    wbuf[s_addr] = s_d;
                    if (int'(s_addr) + 1 > wlen) wlen = int'(s_addr) + 1;
                end
                if (s_winc && wlen != 0) begin
                    for (int i = 0; i < 16; i++) s_pk[i*8 +: 8] = wbuf[i];
                    q_data.push_back(s_pk);
                    q_len.push_back(wlen);
                    wlen = 0;
                end
            end else if (s_winc) begin
                m_drop = 1'b1;
            end
        end
        #1;
        if (armed) begin
            chk("vld_out", bus.vld_out, m_send);
            if (m_send) begin
                chk("data_out", bus.data_out, q_data[0][m_idx*8 +: 8]);
                chk("last_out", bus.last_out, (m_idx == q_len[0] - 1));
            end
            chk("wfull", bus.wfull, (q_len.size() == 2));
            chk("drop_err", bus.drop_err, m_drop);
            chk("timeout_err", bus.timeout_err, m_tmo);
        end
        if (bus.drop_err === 1'b1) n_drop_seen++;
        if (bus.timeout_err === 1'b1) n_tmo_seen++;
        if (bus.vld_out === 1'b1 && !p_vld) rise_cyc = cyc;
        p_vld  = (bus.vld_out === 1'b1);
        p_data = bus.data_out;
    end

    task automatic cyc_drive(input logic we, input logic [3:0] a, input logic [7:0] d, input logic inc);
        bus.wen   = we;
        bus.waddr = a;
        bus.wdata = d;
        bus.winc  = inc;
        @(negedge clk1);
        bus.wen  = 1'b0;
        bus.winc = 1'b0;
    endtask

    // sep=1 commits in a separate cycle, sep=0 commits together with the last byte.
    task automatic send_pkt(input int n, input logic [7:0] base, input bit sep);
        for (int i = 0; i < n; i++)
            cyc_drive(1'b1, 4'(i), 8'(base + 8'(i)), (!sep && i == n - 1));
        if (sep) cyc_drive(1'b0, 4'd0, 8'd0, 1'b1);
    endtask

    task automatic wait_vld();
        int k = 0;
        while (bus.vld_out !== 1'b1 && k < 50) begin
            @(negedge clk1);
            k++;
        end
        chk("wait_vld_bound", (k < 50), 1);
    endtask

    task automatic drain();
        int k = 0;
        bus.read_enb = 1'b1;
        while ((q_len.size() != 0 || bus.vld_out !== 1'b0) && k < 200) begin
            @(negedge clk1);
            k++;
        end
        chk("drain_bound", (k < 200), 1);
        repeat (2) @(negedge clk1);
    endtask

    task automatic chk_got(input string nm);
        chk({nm, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(nm, got[i], exp_q[i]);
        got.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.winc = 1'b0; bus.read_enb = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk1);
        chk("rst_vld", bus.vld_out, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_last", bus.last_out, 0);
        chk("rst_wfull", bus.wfull, 0);
        chk("rst_drop", bus.drop_err, 0);
        chk("rst_tmo", bus.timeout_err, 0);
        rst = 1'b1;

        // Single packet, separate commit, consumer always ready.
        bus.read_enb = 1'b1;
        send_pkt(4, 8'hA0, 1'b1);
        drain();
        chk("t1_latency", rise_cyc - winc_cyc, 1);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        chk_got("t1_bytes");

        // Two stored packets fill the port; a third commit is dropped.
        bus.read_enb = 1'b0;
        send_pkt(3, 8'hB0, 1'b0);
        send_pkt(2, 8'hC0, 1'b0);
        chk("t2_wfull", bus.wfull, 1);
        n_drop_seen = 0;
        cyc_drive(1'b1, 4'd0, 8'hD0, 1'b1);
        repeat (3) @(negedge clk1);
        chk("t2_drop_count", n_drop_seen, 1);
        drain();
        exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hC0, 8'hC1};
        chk_got("t2_bytes");
        chk("t2_wfull_after", bus.wfull, 0);

        // Consumer stalls five cycles mid-packet.
        bus.read_enb = 1'b0;
        send_pkt(6, 8'hE0, 1'b0);
        wait_vld();
        bus.read_enb = 1'b1;
        repeat (2) @(negedge clk1);
        bus.read_enb = 1'b0;
        repeat (5) @(negedge clk1);
        chk("t3_data_held", bus.data_out, 8'hE2);
        drain();
        exp_q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
        chk_got("t3_bytes");

        // Last byte freed on the same edge as a new commit while full.
        bus.read_enb = 1'b0;
        send_pkt(2, 8'hF0, 1'b0);
        send_pkt(1, 8'h70, 1'b0);
        chk("t4_wfull", bus.wfull, 1);
        wait_vld();
        n_drop_seen = 0;
        bus.read_enb = 1'b1;
        @(negedge clk1);
        chk("t4_last_presented", bus.last_out, 1);
        cyc_drive(1'b1, 4'd0, 8'h80, 1'b1);
        chk("t4_wfull_kept", bus.wfull, 1);
        drain();
        chk("t4_no_drop", n_drop_seen, 0);
        exp_q = '{8'hF0, 8'hF1, 8'h70, 8'h80};
        chk_got("t4_bytes");

        // Reset while presenting with both banks full.
        bus.read_enb = 1'b0;
        send_pkt(4, 8'h10, 1'b0);
        send_pkt(2, 8'h20, 1'b0);
        wait_vld();
        chk("t5_wfull_pre", bus.wfull, 1);
        rst = 1'b0;
        @(negedge clk1);
        chk("t5_rst_vld", bus.vld_out, 0);
        chk("t5_rst_wfull", bus.wfull, 0);
        rst = 1'b1;
        got.delete();
        bus.read_enb = 1'b1;
        send_pkt(3, 8'h30, 1'b1);
        drain();
        exp_q = '{8'h30, 8'h31, 8'h32};
        chk_got("t5_bytes");

        // Empty commit is ignored; out-of-order write with an overwrite.
        cyc_drive(1'b0, 4'd0, 8'd0, 1'b1);
        repeat (3) @(negedge clk1);
        chk("t6_empty_commit", bus.vld_out, 0);
        cyc_drive(1'b1, 4'd1, 8'h42, 1'b0);
        cyc_drive(1'b1, 4'd0, 8'h41, 1'b0);
        cyc_drive(1'b1, 4'd0, 8'h43, 1'b1);
        drain();
        exp_q = '{8'h43, 8'h42};
        chk_got("t6_bytes");

`ifdef PKT_BUF_TIMEOUT_EN
        bus.read_enb = 1'b0;
        n_tmo_seen = 0;
        send_pkt(2, 8'h50, 1'b0);
        send_pkt(1, 8'h60, 1'b0);
        repeat (40) @(negedge clk1);
        chk("t7_tmo_count", n_tmo_seen, 1);
        drain();
        exp_q = '{8'h60};
        chk_got("t7_bytes");
`else
        bus.read_enb = 1'b0;
        n_tmo_seen = 0;
        send_pkt(2, 8'h50, 1'b0);
        repeat (100) @(negedge clk1);
        chk("t7_no_tmo", n_tmo_seen, 0);
        chk("t7_still_vld", bus.vld_out, 1);
        drain();
        exp_q = '{8'h50, 8'h51};
        chk_got("t7_bytes");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
